// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads and a built-in clear sequencer.
// Optional macro REGFILE_BYPASS_EN selects write-first reads; default is read-first.
module regfile_mp #(
    parameter int NUM_ADDR_BITS = 6,
    parameter int REG_WIDTH     = 32,
    parameter int NUM_RD_PORTS  = 3,
    parameter int NUM_WR_PORTS  = 2,
    parameter int ZERO_REG      = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  clearReq,
    output logic                                  ready,
    input  logic [NUM_WR_PORTS-1:0]               writeEnable,
    input  logic [NUM_WR_PORTS*NUM_ADDR_BITS-1:0] wrAddr,
    input  logic [NUM_WR_PORTS*REG_WIDTH-1:0]     wrData,
    output logic                                  wrConflict,
    input  logic [NUM_RD_PORTS*NUM_ADDR_BITS-1:0] rdAddr,
    output logic [NUM_RD_PORTS*REG_WIDTH-1:0]     rdData,
    output logic                                  debugState
);

    localparam int DEPTH = 1 << NUM_ADDR_BITS;
    localparam logic [NUM_ADDR_BITS-1:0] LAST_ENTRY = '1;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } stateT;

    stateT                           state;
    stateT                           stateNext;
    logic [NUM_ADDR_BITS-1:0]        clearCount;
    logic [REG_WIDTH-1:0]            mem [DEPTH];
    logic                            wrActive;
    logic [NUM_WR_PORTS-1:0]         wrValid;
    logic                            conflictNext;
    logic [NUM_RD_PORTS*REG_WIDTH-1:0] rdNext;

    assign ready      = (state == READY);
    assign debugState = state;

    always_comb begin
        stateNext = state;
        case (state)
            CLEAR:   if (clearCount == LAST_ENTRY) stateNext = READY;
            READY:   if (clearReq) stateNext = CLEAR;
            default: stateNext = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            clearCount <= '0;
        end else begin
            state <= stateNext;
            if (state == CLEAR) clearCount <= clearCount + 1'b1;
            else                clearCount <= '0;
        end
    end

    // A write is real only in READY, outside a clear request, and not aimed at a hardwired zero entry.
    always_comb begin
        wrActive = (state == READY) && !clearReq && !reset;
        wrValid  = '0;
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            wrValid[p] = wrActive && writeEnable[p] &&
                         !((ZERO_REG != 0) && (wrAddr[p*NUM_ADDR_BITS +: NUM_ADDR_BITS] == '0));
        end
    end

    always_comb begin
        conflictNext = 1'b0;
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            for (int q = p + 1; q < NUM_WR_PORTS; q++) begin
                if (wrValid[p] && wrValid[q] &&
                    (wrAddr[p*NUM_ADDR_BITS +: NUM_ADDR_BITS] == wrAddr[q*NUM_ADDR_BITS +: NUM_ADDR_BITS]))
                    conflictNext = 1'b1;
            end
        end
    end

    always_comb begin
        rdNext = '0;
        for (int r = 0; r < NUM_RD_PORTS; r++) begin
            rdNext[r*REG_WIDTH +: REG_WIDTH] = mem[rdAddr[r*NUM_ADDR_BITS +: NUM_ADDR_BITS]];
`ifdef REGFILE_BYPASS_EN
            // Later ports override earlier ones, matching the write priority.
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                if (wrValid[p] &&
                    (wrAddr[p*NUM_ADDR_BITS +: NUM_ADDR_BITS] == rdAddr[r*NUM_ADDR_BITS +: NUM_ADDR_BITS]))
                    rdNext[r*REG_WIDTH +: REG_WIDTH] = wrData[p*REG_WIDTH +: REG_WIDTH];
            end
`else
`endif
            if ((ZERO_REG != 0) && (rdAddr[r*NUM_ADDR_BITS +: NUM_ADDR_BITS] == '0))
                rdNext[r*REG_WIDTH +: REG_WIDTH] = '0;
            if (state != READY)
                rdNext[r*REG_WIDTH +: REG_WIDTH] = '0;
        end
    end

    // Loop order gives the highest-indexed port the last word on a shared address.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clearCount] <= '0;
        end else begin
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                if (wrValid[p])
                    mem[wrAddr[p*NUM_ADDR_BITS +: NUM_ADDR_BITS]] <= wrData[p*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdData     <= '0;
            wrConflict <= 1'b0;
        end else begin
            rdData     <= rdNext;
            wrConflict <= conflictNext;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed plus short random test of regfile_mp with a read-data scoreboard.
// A second instance with ZERO_REG=0 checks the ordinary entry-0 behaviour.
module tb_regfile_mp;

    localparam int A  = 6;
    localparam int W  = 32;
    localparam int NR = 3;
    localparam int NW = 2;

    logic              clk;
    logic              reset;
    logic              clearReq;
    logic [NW-1:0]     writeEnable;
    logic [NW*A-1:0]   wrAddr;
    logic [NW*W-1:0]   wrData;
    logic [NR*A-1:0]   rdAddr;
    logic              ready, readyNz;
    logic              wrConflict, wrConflictNz;
    logic [NR*W-1:0]   rdData, rdDataNz;
    logic              debugState, debugStateNz;

    int compared   = 0;
    int mismatched = 0;

    logic [W-1:0] expQ [$];
    int           portQ [$];
    logic [W-1:0] model [64];

    regfile_mp #(.NUM_ADDR_BITS(A), .REG_WIDTH(W), .NUM_RD_PORTS(NR), .NUM_WR_PORTS(NW), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .clearReq(clearReq), .ready(ready),
        .writeEnable(writeEnable), .wrAddr(wrAddr), .wrData(wrData), .wrConflict(wrConflict),
        .rdAddr(rdAddr), .rdData(rdData), .debugState(debugState)
    );

    regfile_mp #(.NUM_ADDR_BITS(A), .REG_WIDTH(W), .NUM_RD_PORTS(NR), .NUM_WR_PORTS(NW), .ZERO_REG(0)) dutNz (
        .clk(clk), .reset(reset), .clearReq(clearReq), .ready(readyNz),
        .writeEnable(writeEnable), .wrAddr(wrAddr), .wrData(wrData), .wrConflict(wrConflictNz),
        .rdAddr(rdAddr), .rdData(rdDataNz), .debugState(debugStateNz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setWrite(input int p, input logic en, input logic [A-1:0] a, input logic [W-1:0] d);
        writeEnable[p]  = en;
        wrAddr[p*A +: A] = a;
        wrData[p*W +: W] = d;
    endtask

    task automatic issueRead(input int r, input logic [A-1:0] a, input logic [W-1:0] e);
        rdAddr[r*A +: A] = a;
        expQ.push_back(e);
        portQ.push_back(r);
    endtask

    task automatic drain();
        logic [W-1:0] e;
        int r;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            r = portQ.pop_front();
            check("rdData", rdData[r*W +: W], e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    // Counts cycles with ready low; optionally drives junk writes and a clearReq that must be ignored.
    task automatic countClear(output int cnt, input logic junk);
        cnt = 0;
        while (!ready && cnt < 200) begin
            cnt++;
            issueRead(cnt % NR, A'($urandom_range(0, 63)), '0);
            if (junk) begin
                setWrite(0, 1'b1, 6'h09, $urandom);
                setWrite(1, 1'b1, 6'h09, $urandom);
                clearReq = (cnt == 20);
            end
            step();
            check("wrConflictInClear", {31'b0, wrConflict}, '0);
        end
        setWrite(0, 1'b0, '0, '0);
        setWrite(1, 1'b0, '0, '0);
        clearReq = 1'b0;
    endtask

    initial begin
        int cnt;
        logic [NW-1:0]  en;
        logic [A-1:0]   wa [NW];
        logic [W-1:0]   wd [NW];
        logic [A-1:0]   ra;
        logic [W-1:0]   e;
        logic           expConf;

        reset = 1'b1; clearReq = 1'b0; writeEnable = '0; wrAddr = '0; wrData = '0; rdAddr = '0;
        step();
        check("resetReady", {31'b0, ready}, '0);
        check("resetConflict", {31'b0, wrConflict}, '0);
        check("resetRdData", rdData[W-1:0], '0);
        check("resetState", {31'b0, debugState}, '0);
        reset = 1'b0;

        // Initial clear, with ignored writes and clearReq mid-sequence.
        countClear(cnt, 1'b1);
        check("clearCycles", cnt, 64);
        check("readyState", {31'b0, debugState}, 32'd1);
        for (int a = 0; a < 64; a++) begin
            issueRead(a % NR, A'(a), '0);
            step();
        end

        // Simple write then shared-address read on ports A and C.
        setWrite(0, 1'b1, 6'h01, 32'h14578BB0);
        step();
        setWrite(0, 1'b0, '0, '0);
        issueRead(0, 6'h01, 32'h14578BB0);
        issueRead(2, 6'h01, 32'h14578BB0);
        step();
        check("noConflictSingle", {31'b0, wrConflict}, '0);

        // Same-address collision: port 1 wins, flag for one cycle.
        setWrite(0, 1'b1, 6'h02, 32'h00000001);
        setWrite(1, 1'b1, 6'h02, 32'hFFFFFFFF);
        step();
        setWrite(0, 1'b0, '0, '0);
        setWrite(1, 1'b0, '0, '0);
        check("conflictSet", {31'b0, wrConflict}, 32'd1);
        issueRead(1, 6'h02, 32'hFFFFFFFF);
        step();
        check("conflictOneCycle", {31'b0, wrConflict}, '0);

        // Entry 0: hardwired in dut, ordinary in dutNz.
        setWrite(0, 1'b1, 6'h00, 32'h12345678);
        setWrite(1, 1'b1, 6'h00, 32'h88888888);
        step();
        setWrite(0, 1'b0, '0, '0);
        setWrite(1, 1'b0, '0, '0);
        check("zeroRegNoConflict", {31'b0, wrConflict}, '0);
        check("nzConflict", {31'b0, wrConflictNz}, 32'd1);
        issueRead(1, 6'h00, '0);
        step();
        check("nzRead0", rdDataNz[W +: W], 32'h88888888);

        // Read and write of the last entry in the same cycle.
        setWrite(0, 1'b1, 6'h3F, 32'hA5A5A5A5);
        step();
        setWrite(0, 1'b1, 6'h3F, 32'h00000001);
`ifdef REGFILE_BYPASS_EN
        issueRead(0, 6'h3F, 32'h00000001);
`else
        issueRead(0, 6'h3F, 32'hA5A5A5A5);
`endif
        step();
        setWrite(0, 1'b0, '0, '0);
        for (int r = 0; r < NR; r++) issueRead(r, 6'h3F, 32'h00000001);
        step();

        // clearReq drops same-cycle writes (no conflict flagged) and re-zeroes the file.
        clearReq = 1'b1;
        setWrite(0, 1'b1, 6'h05, 32'hDDDDDDDD);
        setWrite(1, 1'b1, 6'h05, 32'hDDDDDDDD);
        step();
        clearReq = 1'b0;
        setWrite(0, 1'b0, '0, '0);
        setWrite(1, 1'b0, '0, '0);
        check("clearReqDropsConflict", {31'b0, wrConflict}, '0);
        countClear(cnt, 1'b0);
        check("reclearCycles", cnt, 64);
        issueRead(0, 6'h01, '0);
        issueRead(1, 6'h05, '0);
        issueRead(2, 6'h3F, '0);
        step();

        // Reset at clear cycle 10 restarts the full count.
        setWrite(0, 1'b1, 6'h01, 32'h14578BB0);
        step();
        setWrite(0, 1'b0, '0, '0);
        clearReq = 1'b1;
        step();
        clearReq = 1'b0;
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        countClear(cnt, 1'b0);
        check("resetMidClearCycles", cnt, 64);
        issueRead(0, 6'h01, '0);
        step();

        // Random traffic against a reference model on a narrow address range.
        for (int i = 0; i < 64; i++) model[i] = '0;
        for (int i = 0; i < 40; i++) begin
            for (int p = 0; p < NW; p++) begin
                en[p] = 1'($urandom_range(0, 1));
                wa[p] = A'($urandom_range(0, 7));
                wd[p] = $urandom;
                setWrite(p, en[p], wa[p], wd[p]);
            end
            for (int r = 0; r < NR; r++) begin
                ra = A'($urandom_range(0, 7));
                e  = model[ra];
`ifdef REGFILE_BYPASS_EN
                for (int p = 0; p < NW; p++)
                    if (en[p] && wa[p] != '0 && wa[p] == ra) e = wd[p];
`endif
                if (ra == '0) e = '0;
                issueRead(r, ra, e);
            end
            expConf = en[0] && en[1] && (wa[0] == wa[1]) && (wa[0] != '0);
            for (int p = 0; p < NW; p++)
                if (en[p] && wa[p] != '0) model[wa[p]] = wd[p];
            step();
            check("randConflict", {31'b0, wrConflict}, {31'b0, expConf});
        end
        setWrite(0, 1'b0, '0, '0);
        setWrite(1, 1'b0, '0, '0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
